// File: rtl/bg_gen_fx.sv
// rtl/bg_gen_fx.sv - themed maze background generator with frame-synchronous flash sequencer
module bg_gen_fx #(
    parameter int TILE_SIZE    = 16,
    parameter int MAZE_X0_T    = 5,
    parameter int MAZE_X1_T    = 33,
    parameter int MAZE_Y1_T    = 29,
    parameter int NUM_THEMES   = 4,
    parameter int FLASH_FRAMES = 15,
    parameter int FLASH_PHASES = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] pixel_x,
    input  logic [10:0] pixel_y,
    input  logic        frame_start,
    input  logic [1:0]  theme_sel,
    input  logic        flash_start,
    output logic [7:0]  RGB_out,
    output logic [1:0]  theme_active,
    output logic        flash_busy
);

    localparam logic [10:0] MAZE_X0 = 11'(MAZE_X0_T * TILE_SIZE);
    localparam logic [10:0] MAZE_X1 = 11'(MAZE_X1_T * TILE_SIZE);
    localparam logic [10:0] MAZE_Y1 = 11'(MAZE_Y1_T * TILE_SIZE);
    localparam logic [2:0]  THEME_LIMIT = 3'(NUM_THEMES);

    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
    localparam int PW = (FLASH_PHASES > 1) ? $clog2(FLASH_PHASES) : 1;
    localparam logic [FW-1:0] FRAME_LAST = FW'(FLASH_FRAMES - 1);
    localparam logic [PW-1:0] PHASE_LAST = PW'(FLASH_PHASES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } flash_state_t;

    flash_state_t    r_state;
    flash_state_t    w_state_nxt;
    logic [FW-1:0]   r_frame_cnt;
    logic [FW-1:0]   w_frame_nxt;
    logic [PW-1:0]   r_phase_cnt;
    logic [PW-1:0]   w_phase_nxt;
    logic [1:0]      r_theme;
    logic [7:0]      r_rgb;

    logic            w_in_maze;
    logic [7:0]      w_interior;
    logic [7:0]      w_exterior;
    logic [7:0]      w_rgb_nxt;
    logic            w_theme_ok;

    assign w_theme_ok = ({1'b0, theme_sel} < THEME_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_frame_cnt <= '0;
            r_phase_cnt <= '0;
            r_theme     <= 2'd0;
            r_rgb       <= 8'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_frame_cnt <= w_frame_nxt;
            r_phase_cnt <= w_phase_nxt;
            r_rgb       <= w_rgb_nxt;
            if (frame_start && w_theme_ok) begin
                r_theme <= theme_sel;
            end
        end
    end

    // Flash sequencer advances only on frame boundaries; flash_start is ignored once armed
    always_comb begin
        w_state_nxt = r_state;
        w_frame_nxt = r_frame_cnt;
        w_phase_nxt = r_phase_cnt;
        case (r_state)
            ST_IDLE: begin
                if (flash_start) begin
                    w_state_nxt = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (frame_start) begin
                    w_state_nxt = ST_RUN;
                    w_frame_nxt = '0;
                    w_phase_nxt = '0;
                end
            end
            ST_RUN: begin
                if (frame_start) begin
                    if (r_frame_cnt != FRAME_LAST) begin
                        w_frame_nxt = r_frame_cnt + 1'b1;
                    end else begin
                        w_frame_nxt = '0;
                        if (r_phase_cnt == PHASE_LAST) begin
                            w_state_nxt = ST_IDLE;
                            w_phase_nxt = '0;
                        end else begin
                            w_phase_nxt = r_phase_cnt + 1'b1;
                        end
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_frame_nxt = '0;
                w_phase_nxt = '0;
            end
        endcase
    end

    assign w_in_maze = (pixel_x > MAZE_X0) && (pixel_x < MAZE_X1) && (pixel_y < MAZE_Y1);

    always_comb begin
        w_interior = 8'h00;
        w_exterior = 8'h92;
        case (r_theme)
            2'd0: begin w_interior = 8'h00; w_exterior = 8'h92; end
            2'd1: begin w_interior = 8'hFF; w_exterior = 8'h92; end
            2'd2: begin w_interior = 8'h02; w_exterior = 8'h49; end
            2'd3: begin w_interior = 8'h1C; w_exterior = 8'h49; end
            default: begin w_interior = 8'h00; w_exterior = 8'h92; end
        endcase
    end

    // Even flash phases invert the interior; the exterior is never flashed
    always_comb begin
        w_rgb_nxt = w_interior;
        if (!w_in_maze) begin
            w_rgb_nxt = w_exterior;
        end else if ((r_state == ST_RUN) && !r_phase_cnt[0]) begin
            w_rgb_nxt = ~w_interior;
        end
    end

    assign RGB_out      = r_rgb;
    assign theme_active = r_theme;
    assign flash_busy   = (r_state != ST_IDLE);

endmodule

// File: doc/bg_gen_fx.md
# bg_gen_fx

Parametrised, themed maze-background generator with frame-synchronous theme switching and a level-clear flash sequencer. It sits in the VGA pipeline at the lowest layer. For each pixel coordinate it produces one registered 8-bit RGB332 background colour, which the object mux draws over. Theme changes and flash transitions take effect only on frame boundaries, so no frame ever tears.

## Interface
Parameters:
- TILE_SIZE, 16: pixels per maze tile.
- MAZE_X0_T, 5: left maze edge, in tiles (exclusive).
- MAZE_X1_T, 33: right maze edge, in tiles (exclusive).
- MAZE_Y1_T, 29: bottom maze edge, in tiles (exclusive).
- NUM_THEMES, 4: number of palette entries used, 1..4.
- FLASH_FRAMES, 15: frames per flash phase, ≥1.
- FLASH_PHASES, 8: phases per flash sequence, ≥1.

Ports:
- clk in 1: pixel clock.
- reset in 1: asynchronous, active-high reset.
- pixel_x in 11: current pixel column.
- pixel_y in 11: current pixel row.
- frame_start in 1: one-cycle pulse once per frame. Upstream guarantees it falls in vertical blanking.
- theme_sel in 2: requested theme index.
- flash_start in 1: one-cycle request to start a flash sequence.
- RGB_out out 8: registered background colour.
- theme_active out 2: currently applied theme.
- flash_busy out 1: high while a flash sequence is armed or running.

## Operation
- Maze region, combinational: in_maze = (pixel_x > MAZE_X0_T*TILE_SIZE) && (pixel_x < MAZE_X1_T*TILE_SIZE) && (pixel_y < MAZE_Y1_T*TILE_SIZE). All comparisons are unsigned at 11 bits.
- Fixed palette, as interior/exterior colour pairs:
  - theme 0: 8'h00 / 8'h92
  - theme 1: 8'hFF / 8'h92
  - theme 2: 8'h02 / 8'h49
  - theme 3: 8'h1C / 8'h49
- Theme register:
  - On a cycle with frame_start=1, theme_active <= theme_sel if theme_sel < NUM_THEMES.
  - Otherwise theme_active holds. Out-of-range requests are ignored.
  - theme_sel is not observed at any other time.
- Flash FSM, with state, frame_cnt (counts 0..FLASH_FRAMES-1) and phase_cnt (counts 0..FLASH_PHASES-1):
  - IDLE: flash_start=1 → ARMED.
  - ARMED: frame_start=1 → RUN, with frame_cnt=0 and phase_cnt=0.
  - RUN: on each frame_start:
    - If frame_cnt < FLASH_FRAMES-1, frame_cnt++.
    - Otherwise frame_cnt=0. Then if phase_cnt == FLASH_PHASES-1 → IDLE, else phase_cnt++.
  - flash_start is ignored in ARMED and RUN; there is no queueing.
  - flash_start and frame_start together in IDLE → ARMED only. RUN starts at the next frame_start.
- flash_busy = (state != IDLE).
- Colour selection, in priority order:
  - !in_maze → exterior colour.
  - in_maze, state==RUN and phase_cnt[0]==0 → ~interior colour (bitwise inverse).
  - otherwise → interior colour.
- The flash colour tracks theme_active. A theme change during RUN is legal and is applied at the frame boundary.

## Timing
- RGB_out is registered. The colour for (pixel_x, pixel_y) presented in cycle n appears in cycle n+1. Latency is 1 clock, throughput 1 pixel per clock.
- State, theme_active and flash_busy update on the clock edge that samples frame_start / flash_start.
- The colour registered on a frame_start edge uses the pre-update state. This is harmless because the edge falls in blanking.
- A flash sequence lasts exactly FLASH_FRAMES*FLASH_PHASES frames in RUN, plus the arming wait (0 to 1 frames).
- Reset, asynchronous, any time including mid-flash:
  - RGB_out = 8'h00.
  - theme_active = 0.
  - flash_busy = 0.
  - state = IDLE, frame_cnt = 0, phase_cnt = 0.
- First valid output: the cycle after the first post-reset pixel.

## Test plan
- Reset, theme 0, pixels (100,100), (80,100), (81,100), (528,10), (200,464) → RGB_out one cycle later: 8'h00, 8'h92, 8'h00, 8'h92, 8'h92. This checks the strict edges at x=80, x=528 and y=464.
- theme_sel=1 held mid-frame, no frame_start, then frame_start → theme_active and interior colour stay 0 / 8'h00 until the frame_start edge, then become 1 / 8'hFF.
- theme_sel=3 with NUM_THEMES=2 → theme_active stays at its prior value across frame_start.
- FLASH_FRAMES=2, FLASH_PHASES=4, theme 0, flash_start → flash_busy=1 immediately. Interior then reads 8'hFF for 2 frames, 8'h00 for 2, 8'hFF for 2, 8'h00 for 2. flash_busy drops on the 8th frame_start in RUN. The exterior stays 8'h92 throughout.
- flash_start together with frame_start in IDLE → RUN starts one frame later. A second flash_start during RUN does not extend the sequence.
- reset asserted during RUN phase 1, mid-line → all outputs go to their reset values immediately. After release, the sequence does not resume.
